// File: rtl/mesm6_input_conditioner.sv
// rtl/mesm6_input_conditioner.sv - per-bit synchronise, debounce and edge-detect front end for GPIO inputs
//
// Purpose:
//   Turns raw asynchronous switch/key inputs into clean debounced levels.
//   Each bit is synchronised through two flops and must then hold a new
//   level for DEBOUNCE_CYCLES consecutive synchronised cycles before it is
//   accepted. Accepted changes produce one-cycle rise/fall strobes and,
//   when enabled, set sticky pending flags that drive the interrupt line.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   i_raw      in   WIDTH  raw asynchronous inputs
//   i_rise_en  in   WIDTH  per-bit: accepted rising edge sets pending
//   i_fall_en  in   WIDTH  per-bit: accepted falling edge sets pending
//   i_ack      in   WIDTH  write-1-to-clear for pending bits
//   o_state    out  WIDTH  debounced level (registered)
//   o_rise     out  WIDTH  one-cycle strobe on accepted 0->1
//   o_fall     out  WIDTH  one-cycle strobe on accepted 1->0
//   o_pending  out  WIDTH  sticky edge flags
//   o_irq      out  1      OR of o_pending

module mesm6_input_conditioner #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  input  logic [WIDTH-1:0] i_rise_en,
  input  logic [WIDTH-1:0] i_fall_en,
  input  logic [WIDTH-1:0] i_ack,
  output logic [WIDTH-1:0] o_state,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_pending,
  output logic             o_irq
);

  // Elaboration-time parameter sanity.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("mesm6_input_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("mesm6_input_conditioner: CNT_W too small to hold DEBOUNCE_CYCLES-1");
  end

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_pending;

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_rise_c;
  logic [WIDTH-1:0] w_fall_c;

  // A bit is accepted on the edge where it has already differed from the
  // accepted level for DEBOUNCE_CYCLES-1 counted cycles plus this one.
  always_comb begin
    w_term = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_term[i] = (r_cnt[i] == TERM);
    end
  end

  assign w_diff   = r_s ^ r_state;
  assign w_accept = w_diff & w_term;
  assign w_rise_c = w_accept & r_s;
  assign w_fall_c = w_accept & ~r_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1      <= '0;
      r_s       <= '0;
      r_state   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_pending <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1    <= i_raw;
      r_s     <= r_s1;
      r_state <= r_state ^ w_accept;
      r_rise  <= w_rise_c;
      r_fall  <= w_fall_c;
      // New edge events take priority over a coincident acknowledge.
      r_pending <= (w_rise_c & i_rise_en) | (w_fall_c & i_fall_en)
                 | (r_pending & ~i_ack);
      // Counter restarts whenever the input agrees with the accepted level
      // and on acceptance, so it never advances past TERM.
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_diff[i] || w_term[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_state   = r_state;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_pending = r_pending;
  assign o_irq     = |r_pending;

endmodule
